// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one EX-stage ALU between the main pipeline (port 0)
// and the auxiliary/debug issue path (port 1). One op in flight at a time;
// operands are registered, the ALU result/status are captured, and the
// result is returned to the issuing port. Owns the architectural {Z,C,N,V}
// register that feeds the ALU carry-in.
//
// Build option: define ALU_ARB_FIXED_PRIO_EN for fixed priority (port 0 wins
// ties, no last_grant state). Default build is round-robin.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no op in flight; granted requester sees ready
// EXEC  | ALU driven from operand regs; result/status captured at the edge
// RESP  | result held for the owner until it handshakes
module alu_share_arbiter #(
  parameter int DATA_W = 32,
  parameter int CMD_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_val1,
  input  logic [DATA_W-1:0] req0_val2,
  input  logic [CMD_W-1:0]  req0_cmd,
  input  logic              req0_s,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_val1,
  input  logic [DATA_W-1:0] req1_val2,
  input  logic [CMD_W-1:0]  req1_cmd,
  input  logic              req1_s,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [DATA_W-1:0] rsp0_res,
  output logic [3:0]        rsp0_sr,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp1_res,
  output logic [3:0]        rsp1_sr,
  output logic [DATA_W-1:0] alu_val1,
  output logic [DATA_W-1:0] alu_val2,
  output logic              alu_carry,
  output logic [CMD_W-1:0]  alu_cmd,
  input  logic [DATA_W-1:0] alu_res,
  input  logic [3:0]        alu_sr,
  output logic [3:0]        status_q
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] op_val1_q, op_val2_q, res_q;
  logic [CMD_W-1:0]  op_cmd_q;
  logic              op_s_q;
  logic              owner_q;
  logic [3:0]        sr_q;
  logic              grant;
  logic              accept;

`ifdef ALU_ARB_FIXED_PRIO_EN
  // Fixed priority: port 1 only wins when port 0 is not asking.
  always_comb begin
    grant = ~req0_valid;
  end
`else
  logic last_grant_q;

  // Round-robin: on a tie, pick the port that did not win last time.
  always_comb begin
    if (req0_valid && req1_valid) grant = ~last_grant_q;
    else                          grant = req1_valid;
  end

  // Remember the winner of each accepted request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         last_grant_q <= 1'b1;
    else if (accept) last_grant_q <= grant;
  end
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next state, handshakes and ALU drive; ALU sees zeros outside EXEC.
  always_comb begin
    state_d    = state_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    accept     = 1'b0;
    alu_val1   = '0;
    alu_val2   = '0;
    alu_cmd    = '0;
    alu_carry  = status_q[2];
    case (state_q)
      S_IDLE: begin
        req0_ready = req0_valid & ~grant;
        req1_ready = req1_valid & grant;
        accept     = req0_ready | req1_ready;
        if (accept) state_d = S_EXEC;
      end
      S_EXEC: begin
        alu_val1 = op_val1_q;
        alu_val2 = op_val2_q;
        alu_cmd  = op_cmd_q;
        state_d  = S_RESP;
      end
      S_RESP: begin
        rsp0_valid = ~owner_q;
        rsp1_valid = owner_q;
        if ((rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready))
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Operand capture on accept, result/status capture at the end of EXEC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_val1_q <= '0;
      op_val2_q <= '0;
      op_cmd_q  <= '0;
      op_s_q    <= 1'b0;
      owner_q   <= 1'b0;
      res_q     <= '0;
      sr_q      <= '0;
      status_q  <= '0;
    end else begin
      if (accept) begin
        op_val1_q <= grant ? req1_val1 : req0_val1;
        op_val2_q <= grant ? req1_val2 : req0_val2;
        op_cmd_q  <= grant ? req1_cmd  : req0_cmd;
        op_s_q    <= grant ? req1_s    : req0_s;
        owner_q   <= grant;
      end
      if (state_q == S_EXEC) begin
        res_q <= alu_res;
        sr_q  <= alu_sr;
        if (op_s_q) status_q <= alu_sr;
      end
    end
  end

  assign rsp0_res = res_q;
  assign rsp1_res = res_q;
  assign rsp0_sr  = sr_q;
  assign rsp1_sr  = sr_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: behavioural ALU on the ALU side, per-port
// scoreboards of expected results, grant-order log.
module tb_alu_share_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_val1 = '0, req0_val2 = '0, req1_val1 = '0, req1_val2 = '0;
  logic [3:0]  req0_cmd = '0, req1_cmd = '0;
  logic        req0_s = 1'b0, req1_s = 1'b0;
  logic        rsp0_valid, rsp1_valid;
  logic        rsp0_ready = 1'b1, rsp1_ready = 1'b1;
  logic [31:0] rsp0_res, rsp1_res;
  logic [3:0]  rsp0_sr, rsp1_sr;
  logic [31:0] alu_val1, alu_val2, alu_res;
  logic        alu_carry;
  logic [3:0]  alu_cmd, alu_sr, status_q;

  typedef struct packed {
    logic [31:0] res;
    logic [3:0]  sr;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   glog[$];
  int   n_chk = 0;
  int   n_fail = 0;

  alu_share_arbiter #(.DATA_W(32), .CMD_W(4)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_val1(req0_val1),
    .req0_val2(req0_val2), .req0_cmd(req0_cmd), .req0_s(req0_s),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_val1(req1_val1),
    .req1_val2(req1_val2), .req1_cmd(req1_cmd), .req1_s(req1_s),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_res(rsp0_res), .rsp0_sr(rsp0_sr),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_res(rsp1_res), .rsp1_sr(rsp1_sr),
    .alu_val1(alu_val1), .alu_val2(alu_val2), .alu_carry(alu_carry), .alu_cmd(alu_cmd),
    .alu_res(alu_res), .alu_sr(alu_sr), .status_q(status_q)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: MOV/ADD/ADC/SUB/CMP, C is carry out / borrow.
  logic [32:0] r33;
  logic        v_flag;
  always_comb begin
    r33    = '0;
    v_flag = 1'b0;
    case (alu_cmd)
      4'b0001: r33 = {1'b0, alu_val2};
      4'b0010: begin
        r33    = {1'b0, alu_val1} + {1'b0, alu_val2};
        v_flag = (alu_val1[31] == alu_val2[31]) && (r33[31] != alu_val1[31]);
      end
      4'b0011: begin
        r33    = {1'b0, alu_val1} + {1'b0, alu_val2} + {32'd0, alu_carry};
        v_flag = (alu_val1[31] == alu_val2[31]) && (r33[31] != alu_val1[31]);
      end
      4'b0100, 4'b1100: begin
        r33    = {1'b0, alu_val1} - {1'b0, alu_val2};
        v_flag = (alu_val1[31] != alu_val2[31]) && (r33[31] != alu_val1[31]);
      end
      default: r33 = '0;
    endcase
    alu_res = r33[31:0];
    alu_sr  = {(r33[31:0] == 32'd0), r33[32], r33[31], v_flag};
  end

  task automatic chk_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Handshakes are sampled at the falling edge; inputs only move just after rising edges.
  always @(negedge clk) begin
    if (!rst) begin
      if (req0_valid && req0_ready) glog.push_back(0);
      if (req1_valid && req1_ready) glog.push_back(1);
      if (rsp0_valid && rsp0_ready) begin
        if (q0.size() == 0) chk_val("rsp0_unexpected", q0.size(), 1);
        else begin
          exp_t e;
          e = q0.pop_front();
          chk_val("rsp0_res", rsp0_res, e.res);
          chk_val("rsp0_sr", rsp0_sr, e.sr);
        end
      end
      if (rsp1_valid && rsp1_ready) begin
        if (q1.size() == 0) chk_val("rsp1_unexpected", q1.size(), 1);
        else begin
          exp_t e;
          e = q1.pop_front();
          chk_val("rsp1_res", rsp1_res, e.res);
          chk_val("rsp1_sr", rsp1_sr, e.sr);
        end
      end
    end
  end

  // Issue one op on port p; returns just after the accepting edge (DUT in EXEC).
  task automatic send(input int p, input logic [31:0] a, input logic [31:0] b,
                      input logic [3:0] cmd, input logic s, input bit exp_rsp,
                      input logic [31:0] er, input logic [3:0] es);
    int   n;
    logic rdy;
    exp_t e;
    e.res = er;
    e.sr  = es;
    if (p == 0) begin
      req0_val1 = a; req0_val2 = b; req0_cmd = cmd; req0_s = s; req0_valid = 1'b1;
      if (exp_rsp) q0.push_back(e);
    end else begin
      req1_val1 = a; req1_val2 = b; req1_cmd = cmd; req1_s = s; req1_valid = 1'b1;
      if (exp_rsp) q1.push_back(e);
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
      rdy = (p == 0) ? req0_ready : req1_ready;
    end while (!rdy && n < 60);
    chk_val(p == 0 ? "req0_accept" : "req1_accept", rdy, 1'b1);
    @(posedge clk);
    #1;
    if (p == 0) req0_valid = 1'b0;
    else        req1_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 60) begin
      @(posedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    chk_val("drain", (q0.size() == 0) && (q1.size() == 0), 1'b1);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Main sequence.
  initial begin
    int exp_order[4];
    int gsz;

    repeat (2) @(posedge clk);
    #1;
    chk_val("rst_rsp0_valid", rsp0_valid, 1'b0);
    chk_val("rst_rsp1_valid", rsp1_valid, 1'b0);
    chk_val("rst_req0_ready", req0_ready, 1'b0);
    chk_val("rst_req1_ready", req1_ready, 1'b0);
    chk_val("rst_status", status_q, 4'b0000);
    chk_val("rst_alu_cmd", alu_cmd, 4'b0000);
    chk_val("rst_alu_val1", alu_val1, 32'd0);
    rst = 1'b0;

    // ADD 5+7, s=0, with latency check
    send(0, 32'd5, 32'd7, 4'b0010, 1'b0, 1'b1, 32'd12, 4'b0000);
    chk_val("lat_exec_rsp0_valid", rsp0_valid, 1'b0);
    chk_val("exec_req1_ready", req1_ready, 1'b0);
    chk_val("exec_alu_cmd", alu_cmd, 4'b0010);
    @(posedge clk);
    #1;
    chk_val("lat_resp_rsp0_valid", rsp0_valid, 1'b1);
    chk_val("resp_rsp1_valid", rsp1_valid, 1'b0);
    drain();
    chk_val("status_after_s0", status_q, 4'b0000);

    // ADD overflow with s=1, then ADC using stored carry
    send(0, 32'hFFFF_FFFF, 32'h1, 4'b0010, 1'b1, 1'b1, 32'd0, 4'b1100);
    drain();
    chk_val("status_after_add", status_q, 4'b1100);
    chk_val("idle_alu_carry", alu_carry, 1'b1);
    chk_val("idle_alu_cmd", alu_cmd, 4'b0000);
    send(1, 32'd0, 32'd0, 4'b0011, 1'b0, 1'b1, 32'd1, 4'b0000);
    drain();
    chk_val("status_after_adc", status_q, 4'b1100);

    // Both ports requesting continuously
    do_reset();
    chk_val("rst2_status", status_q, 4'b0000);
    glog.delete();
    fork
      for (int i = 0; i < 4; i++)
        send(0, 32'd10 + i, 32'd100, 4'b0010, 1'b0, 1'b1, 32'd110 + i, 4'b0000);
      for (int j = 0; j < 4; j++)
        send(1, 32'd20 + j, 32'd100, 4'b0010, 1'b0, 1'b1, 32'd120 + j, 4'b0000);
    join
    drain();
`ifdef ALU_ARB_FIXED_PRIO_EN
    exp_order = '{0, 0, 0, 0};
`else
    exp_order = '{0, 1, 0, 1};
`endif
    chk_val("grant_count", glog.size(), 8);
    if (glog.size() >= 4)
      for (int k = 0; k < 4; k++) chk_val($sformatf("grant_order%0d", k), glog[k], exp_order[k]);

    // SUB 3-3 on port 1 with response back-pressure; port 0 waits
    rsp1_ready = 1'b0;
    send(1, 32'd3, 32'd3, 4'b0100, 1'b0, 1'b1, 32'd0, 4'b1000);
    gsz = glog.size();
    fork
      send(0, 32'd1, 32'd1, 4'b0010, 1'b0, 1'b1, 32'd2, 4'b0000);
    join_none
    @(posedge clk);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk_val("hold_rsp1_valid", rsp1_valid, 1'b1);
      chk_val("hold_rsp1_res", rsp1_res, 32'd0);
      chk_val("hold_rsp1_sr", rsp1_sr, 4'b1000);
      chk_val("hold_req0_ready", req0_ready, 1'b0);
      chk_val("hold_req1_ready", req1_ready, 1'b0);
      chk_val("hold_no_grant", glog.size(), gsz);
    end
    @(posedge clk);
    #1 rsp1_ready = 1'b1;
    wait fork;
    drain();
    chk_val("after_hold_grants", glog.size(), gsz + 1);
    if (glog.size() == gsz + 1) chk_val("after_hold_port", glog[gsz], 0);

    // Preload status 0100, then CMP with reset during EXEC
    send(0, 32'hFFFF_FFFF, 32'd2, 4'b0010, 1'b1, 1'b1, 32'd1, 4'b0100);
    drain();
    chk_val("preload_status", status_q, 4'b0100);
    send(0, 32'd2, 32'd5, 4'b1100, 1'b1, 1'b0, 32'd0, 4'b0000);
    rst = 1'b1;
    #1;
    chk_val("midrst_status", status_q, 4'b0000);
    chk_val("midrst_rsp0_valid", rsp0_valid, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk_val("midrst_no_rsp0", rsp0_valid, 1'b0);
      chk_val("midrst_status_hold", status_q, 4'b0000);
    end

    // Served normally after reset; preload 0100 then MOV with s=0
    @(posedge clk);
    #1;
    send(0, 32'hFFFF_FFFF, 32'd2, 4'b0010, 1'b1, 1'b1, 32'd1, 4'b0100);
    drain();
    chk_val("preload2_status", status_q, 4'b0100);
    send(1, 32'd0, 32'h8000_0000, 4'b0001, 1'b0, 1'b1, 32'h8000_0000, 4'b0010);
    drain();
    chk_val("mov_status_unchanged", status_q, 4'b0100);

    chk_val("sb0_empty", q0.size(), 0);
    chk_val("sb1_empty", q1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
